// File: rtl/cm_arbiter.sv
// Weighted min/max arbiter: balanced compare tree with optional pipeline stages.
// Optional one-hot grant output enabled by defining CM_ARBITER_GNT_OH_EN.
package cm_pkg;
  typedef enum logic {ARB_MIN = 1'b0, ARB_MAX = 1'b1} t_arb_algo;

  function automatic int sclog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

module cm_arbiter_node
  import cm_pkg::*;
#(
  parameter int        DWIDTH = 8,
  parameter int        IW     = 2,
  parameter t_arb_algo ALGO   = ARB_MIN
) (
  input  logic              a_vld,
  input  logic [DWIDTH-1:0] a_wgt,
  input  logic [IW-1:0]     a_idx,
  input  logic              b_vld,
  input  logic [DWIDTH-1:0] b_wgt,
  input  logic [IW-1:0]     b_idx,
  output logic              o_vld,
  output logic [DWIDTH-1:0] o_wgt,
  output logic [IW-1:0]     o_idx
);
  logic b_better, pick_b;

  // 'a' is always the lower-index child, so ties keep 'a'.
  always_comb begin
    b_better = (ALGO == ARB_MAX) ? (b_wgt > a_wgt) : (b_wgt < a_wgt);
    pick_b   = b_vld & (~a_vld | b_better);
    o_vld    = a_vld | b_vld;
    o_wgt    = pick_b ? b_wgt : a_wgt;
    o_idx    = pick_b ? b_idx : a_idx;
  end
endmodule

module cm_arbiter
  import cm_pkg::*;
#(
  parameter int        DCNT      = 4,
  parameter int        DWIDTH    = 8,
  parameter int        REG_CNT   = 0,
  parameter t_arb_algo ALGO      = ARB_MIN,
  localparam int       IDX_WIDTH = sclog2(DCNT)
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [DCNT-1:0]             i_req,
  input  logic [DCNT-1:0][DWIDTH-1:0] i_weight,
  output logic                        o_vld,
  output logic [IDX_WIDTH-1:0]        o_gnt
`ifdef CM_ARBITER_GNT_OH_EN
  ,
  output logic [DCNT-1:0]             o_gnt_oh
`endif
);
  localparam int DEPTH = (DCNT == 1) ? 0 : sclog2(DCNT);
  localparam int NP    = 1 << DEPTH;
  localparam int NODES = 2 * NP - 1;

  typedef struct packed {
    logic                 vld;
    logic [DWIDTH-1:0]    wgt;
    logic [IDX_WIDTH-1:0] idx;
  } node_t;

  // Register stages placed right after tree level 'lvl' (0 = leaves).
  function automatic int regs_at(input int lvl);
    int c;
    c = 0;
    if (REG_CNT > 0)
      for (int k = 1; k <= REG_CNT; k++)
        if ((k * DEPTH + REG_CNT - 1) / REG_CNT == lvl) c++;
    return c;
  endfunction

  // Heap node i sits at depth floor(log2(i+1)); tree level counts up from leaves.
  function automatic int heap_lvl(input int i);
    int d;
    d = 0;
    for (int b = 1; b < 31; b++) if ((1 << b) <= i + 1) d = b;
    return DEPTH - d;
  endfunction

  // Heap layout: root 0, children 2i+1 (lower lanes) and 2i+2, leaf n at NP-1+n.
  node_t [NODES-1:0] tree_o;

  for (genvar i = 0; i < NODES; i++) begin : g_node
    localparam int NR = regs_at(heap_lvl(i));
    node_t node_c;

    if (i >= NP - 1) begin : g_leaf
      localparam int LANE = i - (NP - 1);
      if (LANE < DCNT) begin : g_req
        assign node_c = '{vld: i_req[LANE], wgt: i_weight[LANE], idx: IDX_WIDTH'(LANE)};
      end else begin : g_pad
        assign node_c = '{vld: 1'b0, wgt: '0, idx: IDX_WIDTH'(LANE)};
      end
    end else begin : g_cmp
      cm_arbiter_node #(
        .DWIDTH(DWIDTH),
        .IW    (IDX_WIDTH),
        .ALGO  (ALGO)
      ) u_node (
        .a_vld(tree_o[2*i+1].vld),
        .a_wgt(tree_o[2*i+1].wgt),
        .a_idx(tree_o[2*i+1].idx),
        .b_vld(tree_o[2*i+2].vld),
        .b_wgt(tree_o[2*i+2].wgt),
        .b_idx(tree_o[2*i+2].idx),
        .o_vld(node_c.vld),
        .o_wgt(node_c.wgt),
        .o_idx(node_c.idx)
      );
    end

    if (NR == 0) begin : g_comb
      assign tree_o[i] = node_c;
    end else begin : g_pipe
      node_t [NR-1:0] pipe_d, pipe_q;

      always_comb begin
        pipe_d[0] = node_c;
        for (int s = 1; s < NR; s++) pipe_d[s] = pipe_q[s-1];
      end

      always_ff @(posedge i_clk) begin
        if (i_rst) pipe_q <= '0;
        else       pipe_q <= pipe_d;
      end

      assign tree_o[i] = pipe_q[NR-1];
    end
  end

  node_t root;
  assign root  = tree_o[0];
  assign o_vld = root.vld;
  assign o_gnt = root.vld ? root.idx : '0;

`ifdef CM_ARBITER_GNT_OH_EN
  assign o_gnt_oh = root.vld ? (DCNT'(1) << root.idx) : '0;
`endif

  // Root weight and, in the combinational build, clock/reset have no consumer.
  logic unused_ok;
  assign unused_ok = ^{root.wgt, i_clk, i_rst};
endmodule

// File: tb/tb_cm_arbiter.sv
// Directed checks of cm_arbiter across min/max, padded, pipelined and single-lane builds.
module tb_cm_arbiter;
  import cm_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [3:0]      req4;
  logic [3:0][7:0] w4;
  logic            vld4;
  logic [1:0]      gnt4;

  logic [5:0]      req6m;
  logic [5:0][7:0] w6m;
  logic            vld6m;
  logic [2:0]      gnt6m;

  logic [5:0]      req6p;
  logic [5:0][7:0] w6p;
  logic            vld6p;
  logic [2:0]      gnt6p;

  logic [0:0]      req1;
  logic [0:0][7:0] w1;
  logic            vld1;
  logic [0:0]      gnt1;

  cm_arbiter #(.DCNT(4), .DWIDTH(8), .REG_CNT(0), .ALGO(ARB_MIN)) u_min4 (
    .i_clk(clk), .i_rst(rst), .i_req(req4), .i_weight(w4), .o_vld(vld4), .o_gnt(gnt4));
  cm_arbiter #(.DCNT(6), .DWIDTH(8), .REG_CNT(0), .ALGO(ARB_MAX)) u_max6 (
    .i_clk(clk), .i_rst(rst), .i_req(req6m), .i_weight(w6m), .o_vld(vld6m), .o_gnt(gnt6m));
  cm_arbiter #(.DCNT(6), .DWIDTH(8), .REG_CNT(2), .ALGO(ARB_MIN)) u_pip6 (
    .i_clk(clk), .i_rst(rst), .i_req(req6p), .i_weight(w6p), .o_vld(vld6p), .o_gnt(gnt6p));
  cm_arbiter #(.DCNT(1), .DWIDTH(8), .REG_CNT(1), .ALGO(ARB_MIN)) u_one (
    .i_clk(clk), .i_rst(rst), .i_req(req1), .i_weight(w1), .o_vld(vld1), .o_gnt(gnt1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int gold_min6(input logic [5:0] r, input logic [5:0][7:0] w);
    int   b;
    logic found;
    b = 0;
    found = 1'b0;
    for (int n = 0; n < 6; n++)
      if (r[n] && (!found || w[n] < w[b])) begin
        b = n;
        found = 1'b1;
      end
    return b;
  endfunction

  int exp_g[20];

  initial begin
    req4 = '0; w4 = '0; req6m = '0; w6m = '0;
    req6p = '0; w6p = '0; req1 = '0; w1 = '0;

    // Reset with requests pending on the registered builds
    req6p = 6'h3F; req1 = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_vld6p", 32'(vld6p), 32'd0);
    check("rst_gnt6p", 32'(gnt6p), 32'd0);
    check("rst_vld1",  32'(vld1),  32'd0);
    rst = 1'b0;
    req6p = '0; req1 = '0;

    // DCNT=4 min, combinational
    @(negedge clk);
    req4 = 4'b1111; w4 = {8'h10, 8'h50, 8'h10, 8'h30}; #1;
    check("min4_tie_vld", 32'(vld4), 32'd1);
    check("min4_tie_gnt", 32'(gnt4), 32'd1);
    req4 = 4'b1010; w4 = {8'h05, 8'h00, 8'h09, 8'h00}; #1;
    check("min4_mask_gnt", 32'(gnt4), 32'd3);
    req4 = 4'b0000; w4 = {8'h01, 8'h02, 8'h03, 8'h04}; #1;
    check("min4_none_vld", 32'(vld4), 32'd0);
    check("min4_none_gnt", 32'(gnt4), 32'd0);
    req4 = 4'b0100; w4 = {8'h00, 8'hFF, 8'h00, 8'h00}; #1;
    check("min4_single_gnt", 32'(gnt4), 32'd2);
    req4 = 4'b1111; w4 = '0; #1;
    check("min4_zero_gnt", 32'(gnt4), 32'd0);
    req4 = 4'b1100; w4 = '1; #1;
    check("min4_ones_gnt", 32'(gnt4), 32'd2);

    // DCNT=6 max, combinational, padded tree
    req6m = 6'h3F; w6m = '1; #1;
    check("max6_ones_vld", 32'(vld6m), 32'd1);
    check("max6_ones_gnt", 32'(gnt6m), 32'd0);
    w6m = {8'hFE, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01}; #1;
    check("max6_ramp_gnt", 32'(gnt6m), 32'd5);
    req6m = 6'b110000; w6m = {8'h09, 8'h03, 8'hFF, 8'hFF, 8'hFF, 8'hFF}; #1;
    check("max6_upper_gnt", 32'(gnt6m), 32'd5);
    req6m = 6'b000110; w6m = {8'hFF, 8'hFF, 8'hFF, 8'h07, 8'h07, 8'hFF}; #1;
    check("max6_tie_gnt", 32'(gnt6m), 32'd1);
    req6m = '0; w6m = '1; #1;
    check("max6_none_vld", 32'(vld6m), 32'd0);
    check("max6_none_gnt", 32'(gnt6m), 32'd0);

    // DCNT=6 min, 2-stage pipeline: 20 back-to-back vectors, result 2 cycles later
    for (int j = 0; j < 22; j++) begin
      @(negedge clk);
      if (j >= 2) begin
        check("pip6_vld", 32'(vld6p), 32'd1);
        check("pip6_gnt", 32'(gnt6p), 32'(exp_g[j-2]));
      end
      if (j < 20) begin
        req6p = 6'h3F;
        for (int n = 0; n < 6; n++)
          w6p[n] = (j % 5 == 0) ? 8'h42 : 8'($urandom_range(0, 255));
        exp_g[j] = gold_min6(req6p, w6p);
      end
    end

    // Fill pipeline, then reset while inputs keep requesting
    w6p = {8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
    repeat (2) @(negedge clk);
    check("full_vld", 32'(vld6p), 32'd1);
    check("full_gnt", 32'(gnt6p), 32'd5);
    rst = 1'b1;
    @(negedge clk);
    check("rst1_vld", 32'(vld6p), 32'd0);
    check("rst1_gnt", 32'(gnt6p), 32'd0);
    @(negedge clk);
    check("rst2_vld", 32'(vld6p), 32'd0);
    rst = 1'b0;
    req6p = '0;
    @(negedge clk);
    check("post_rst1_vld", 32'(vld6p), 32'd0);
    check("post_rst1_gnt", 32'(gnt6p), 32'd0);
    @(negedge clk);
    check("post_rst2_vld", 32'(vld6p), 32'd0);

    // Single-lane build with one register
    req1 = 1'b1; w1 = '1;
    @(negedge clk);
    check("one_vld", 32'(vld1), 32'd1);
    check("one_gnt", 32'(gnt1), 32'd0);
    req1 = 1'b0;
    @(negedge clk);
    check("one_idle_vld", 32'(vld1), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
